wave_step_scheduler: RTL and testbench
======================================

# wave_step_scheduler

Time-multiplexes one shared `wave_unit` datapath across all cells of the 1-D wave field. The block owns the `u`/`du` state arrays and sweeps them one cell per cycle to advance the simulation by one time step. Every `STEPS_PER_FRAME` steps it freezes the field and offers a frame to the UART array transmitter through a valid/ack handshake and a random-access read port. It sits between `top` and `transmit_array` and replaces the free-running per-cell update loop.

## Interface
- `N_CELLS`, 100: number of field cells.
- `STEPS_PER_FRAME`, 16: time steps between frame offers; must be ≥1.
- `INIT_LO`, 46: first cell (inclusive) loaded with `INIT_VAL`.
- `INIT_HI`, 54: last cell (inclusive) loaded with `INIT_VAL`.
- `INIT_VAL`, 200000000: initial displacement of the pulse cells.
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `run`, in, 1: level; permits starting new sweeps.
- `busy`, out, 1: high in INIT and SWEEP.
- `frame_valid`, out, 1: field frozen and offered for transmit.
- `frame_ack`, in, 1: transmitter finished; sampled only while `frame_valid`=1.
- `rd_addr`, in, 7: cell index for the frame read port.
- `rd_data`, out, 32: `u[rd_addr]`, combinational; 0 when `rd_addr` ≥ `N_CELLS`.
- `step_count`, out, 16: completed steps since reset; wraps at 2^16.

## Operation
- States: INIT, IDLE, SWEEP, FRAME.
- INIT:
  - Cell index `i` counts 0..N_CELLS-1, writing one cell per cycle.
  - Each write sets `u[i]`=`INIT_VAL` if `INIT_LO`≤i≤`INIT_HI`, else 0, and sets `du[i]`=0.
  - After the last write, go to IDLE.
- IDLE: if `run`=1, go to SWEEP with `i`=0; otherwise stay.
- SWEEP, one cell per cycle, feeding the shared `wave_unit`:
  - Inputs are uL=`prev_u`, u=`u[i]`, uR=`u[i+1]`, du=`du[i]`.
  - `prev_u`=0 at i=0. uR=0 at i=N_CELLS-1, giving fixed zero boundaries.
  - `u[i]`, `du[i]` ← `u_new`, `du_new`; `prev_u` ← old `u[i]`.
  - uR is always a pre-step value, because cell i+1 has not yet been written.
- End of sweep (i=N_CELLS-1): `step_count`++.
  - If the new count mod `STEPS_PER_FRAME`=0, go to FRAME.
  - Else if `run`=1, restart SWEEP with `i`=0.
  - Else go to IDLE.
- FRAME: `frame_valid`=1 and arrays are not written. On `frame_ack`=1, go to IDLE, and from there to SWEEP next cycle if `run`.
- Arithmetic is exactly `wave_unit` semantics, with results truncated to 32 bits:
  - `du_new` = `du` + ((4·(uL+uR−2u))>>8), except `du` is kept unchanged when that term is all-ones.
  - `u_new` = ((u+(du>>8))·2047)>>11, computed at 64-bit width.
- Boundary conditions:
  - Steps are atomic: dropping `run` mid-sweep does not stop the sweep.
  - `frame_ack` outside FRAME is ignored.
  - `reset` in any state returns to INIT and reloads the field. `step_count`=0 and `frame_valid`=0 on the next cycle.
  - `rd_addr` is readable in any state, but data is only coherent in FRAME.

## Timing
- Reset values: `busy`=1, `frame_valid`=0, `step_count`=0; state INIT.
- INIT takes N_CELLS cycles, so IDLE is entered N_CELLS cycles after `reset` drops.
- One step takes N_CELLS cycles. Back-to-back steps have no bubble while `run`=1 and no frame is due.
- `frame_valid` rises the cycle after the last cell write of the frame step.
- `frame_valid` falls the cycle after `frame_ack` is sampled high. The first sweep cell follows one cycle later (IDLE transit).
- `rd_data` has zero latency from `rd_addr`.
- `step_count` updates on the same edge as the last cell write.

## Structure
- Shared package holds:
  - `CELL_W`=32 and `ADDR_W`=7.
  - The state encoding: INIT=0, IDLE=1, SWEEP=2, FRAME=3.
  - The default field constants: `N_CELLS`, `INIT_*`.
- Sub-module: one instance of the existing `wave_unit`, unmodified.
- `u`/`du` are register arrays: the sweep needs two simultaneous combinational reads of `u`.
- `transmit_array` reads through `rd_addr`/`rd_data` instead of a flat bus.

## Test plan
- Reset, then release:
  - `busy`=1 for 100 cycles, then `busy`=0 in IDLE.
  - `rd_addr`=50 → 200000000; `rd_addr`=45 → 0; `rd_addr`=120 → 0.
- `run`=1 for one step, then `run`=0:
  - After 100 cycles, `step_count`=1.
  - `rd_addr`=50 → 199902343 (uL+uR−2u=0, du=0).
  - `rd_addr`=0 → 0.
- `run` held with `STEPS_PER_FRAME`=16:
  - `frame_valid` rises exactly 1600 cycles after sweep start.
  - Arrays stay stable over 500 idle cycles without ack.
  - Ack → next sweep begins 2 cycles later.
- Pulse `frame_ack` in IDLE and mid-SWEEP → no effect on state or `step_count`.
- Assert `reset` at cell 37 of step 3 → INIT reload; `rd_addr`=50 reads 200000000 again after 100 cycles; `step_count`=0.
- Random `run`/`frame_ack` stimulus against a behavioral model of the sweep and `wave_unit`:
  - All cells match after every frame.
  - Boundary cells 0 and 99 always use a 0 neighbour.

Source files
------------

// File: rtl/wave_step_scheduler_pkg.sv
// Shared definitions for the wave field scheduler: datapath widths, FSM
// state encoding and the default field geometry / initial pulse.
package wave_step_scheduler_pkg;

    localparam int CELL_W = 32;
    localparam int ADDR_W = 7;
    localparam int STEP_W = 16;

    localparam int                 DEFAULT_N_CELLS         = 100;
    localparam int                 DEFAULT_STEPS_PER_FRAME = 16;
    localparam int                 DEFAULT_INIT_LO         = 46;
    localparam int                 DEFAULT_INIT_HI         = 54;
    localparam logic [CELL_W-1:0]  DEFAULT_INIT_VAL        = 32'd200000000;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_FRAME = 2'd3
    } sched_state_t;

    // Initial displacement of one cell: a rectangular pulse on [lo, hi].
    function automatic logic [CELL_W-1:0] init_cell_value(
        input logic [ADDR_W-1:0] idx,
        input int                lo,
        input int                hi,
        input logic [CELL_W-1:0] val
    );
        if ((idx >= ADDR_W'(lo)) && (idx <= ADDR_W'(hi)))
            return val;
        return '0;
    endfunction

endpackage

// File: rtl/wave_step_scheduler_wave_unit.sv
// wave_unit: single-cell update of the 1-D wave field (purely combinational).
//   u_l, u, u_r : left neighbour, cell, right neighbour displacement
//   du          : cell velocity
//   u_new       : ((u + (du >>> 8)) * 2047) >>> 11, evaluated at 64 bits
//   du_new      : du + ((4 * laplacian) >>> 8), du held when that term is -1
// All values are two's complement; results are truncated to 32 bits.
module wave_unit
    import wave_step_scheduler_pkg::*;
(
    input  logic [CELL_W-1:0] u_l,
    input  logic [CELL_W-1:0] u,
    input  logic [CELL_W-1:0] u_r,
    input  logic [CELL_W-1:0] du,
    output logic [CELL_W-1:0] u_new,
    output logic [CELL_W-1:0] du_new
);

    logic signed [CELL_W-1:0] lap;
    logic signed [CELL_W-1:0] term;
    logic signed [CELL_W-1:0] du_shift;
    logic signed [63:0]       u_sum;
    logic signed [63:0]       u_mul;

    always_comb begin
        lap      = $signed(u_l) + $signed(u_r) - ($signed(u) <<< 1);
        term     = (lap <<< 2) >>> 8;
        du_shift = $signed(du) >>> 8;
        u_sum    = 64'(signed'(u)) + 64'(du_shift);
        u_mul    = u_sum * 64'sd2047;
        // A tiny negative laplacian floors to -1; it is treated as no force
        // so a settled field does not drift downward.
        du_new   = (term == '1) ? du : du + $unsigned(term);
        u_new    = CELL_W'(u_mul >>> 11);
    end

endmodule

// File: rtl/wave_step_scheduler.sv
// wave_step_scheduler: owns the u/du field arrays and sweeps them one cell
// per cycle through a single shared wave_unit. Every STEPS_PER_FRAME steps
// the field is frozen and offered to the transmitter.
//   clk, reset      : clock, synchronous active-high reset
//   run             : level, permits starting new sweeps
//   busy            : high in INIT and SWEEP
//   frame_valid     : field frozen and offered; frame_ack releases it
//   rd_addr/rd_data : combinational read of u[rd_addr], 0 beyond the field
//   step_count      : completed steps since reset, wraps
//
// state | meaning
// INIT  | loading initial pulse, one cell per cycle
// IDLE  | waiting for run
// SWEEP | updating cell idx through wave_unit
// FRAME | field frozen, waiting for frame_ack
module wave_step_scheduler
    import wave_step_scheduler_pkg::*;
#(
    parameter int                N_CELLS         = DEFAULT_N_CELLS,
    parameter int                STEPS_PER_FRAME = DEFAULT_STEPS_PER_FRAME,
    parameter int                INIT_LO         = DEFAULT_INIT_LO,
    parameter int                INIT_HI         = DEFAULT_INIT_HI,
    parameter logic [CELL_W-1:0] INIT_VAL        = DEFAULT_INIT_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              busy,
    output logic              frame_valid,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CELLS - 1);
    localparam logic [STEP_W-1:0] SPF      = STEP_W'(STEPS_PER_FRAME);

    logic [CELL_W-1:0] u_mem  [N_CELLS];
    logic [CELL_W-1:0] du_mem [N_CELLS];

    sched_state_t      state;
    logic [ADDR_W-1:0] idx;
    logic [CELL_W-1:0] prev_u;

    logic              last_cell;
    logic [CELL_W-1:0] cell_u;
    logic [CELL_W-1:0] cell_ur;
    logic [CELL_W-1:0] cell_du;
    logic [CELL_W-1:0] u_new;
    logic [CELL_W-1:0] du_new;
    logic [STEP_W-1:0] step_next;
    logic              frame_due;

    assign last_cell = (idx == LAST_IDX);
    assign cell_u    = u_mem[idx];
    assign cell_du   = du_mem[idx];
    // Cell idx+1 is not yet written this step, so this is the pre-step value.
    assign cell_ur   = last_cell ? '0 : u_mem[idx + 1'b1];
    assign step_next = step_count + 1'b1;
    assign frame_due = ((step_next % SPF) == '0);
    assign rd_data   = (rd_addr < ADDR_W'(N_CELLS)) ? u_mem[rd_addr] : '0;

    wave_unit u_wave_unit (
        .u_l    (prev_u),
        .u      (cell_u),
        .u_r    (cell_ur),
        .du     (cell_du),
        .u_new  (u_new),
        .du_new (du_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            idx         <= '0;
            prev_u      <= '0;
            step_count  <= '0;
            busy        <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    u_mem[idx]  <= init_cell_value(idx, INIT_LO, INIT_HI, INIT_VAL);
                    du_mem[idx] <= '0;
                    if (last_cell) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (run) begin
                        state  <= ST_SWEEP;
                        busy   <= 1'b1;
                        idx    <= '0;
                        prev_u <= '0;
                    end
                end
                ST_SWEEP: begin
                    u_mem[idx]  <= u_new;
                    du_mem[idx] <= du_new;
                    prev_u      <= cell_u;
                    if (last_cell) begin
                        step_count <= step_next;
                        idx        <= '0;
                        prev_u     <= '0;
                        if (frame_due) begin
                            state       <= ST_FRAME;
                            busy        <= 1'b0;
                            frame_valid <= 1'b1;
                        end else if (!run) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (frame_ack) begin
                        state       <= ST_IDLE;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    busy  <= 1'b1;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_step_scheduler.sv
`timescale 1ns/1ps
module tb_wave_step_scheduler;

    localparam int N   = 100;
    localparam int SPF = 16;
    localparam int LO  = 46;
    localparam int HI  = 54;
    localparam int IV  = 200000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        frame_ack;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        frame_valid;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    int u_m  [N];
    int du_m [N];

    always #5 clk = ~clk;

    wave_step_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .busy        (busy),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .step_count  (step_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < N; i++) begin
            u_m[i]  = (i >= LO && i <= HI) ? IV : 0;
            du_m[i] = 0;
        end
    endfunction

    // One whole time step: both neighbours are taken from the pre-step field.
    function automatic void model_step();
        int old [N];
        int ul, ur, uc, d, term;
        longint prod;
        old = u_m;
        for (int i = 0; i < N; i++) begin
            ul   = (i == 0) ? 0 : old[i-1];
            ur   = (i == N-1) ? 0 : old[i+1];
            uc   = old[i];
            d    = du_m[i];
            term = (4 * (ul + ur - 2 * uc)) >>> 8;
            du_m[i] = (term == -1) ? d : d + term;
            prod = (longint'(uc) + longint'(d >>> 8)) * 64'sd2047;
            u_m[i] = int'(prod >>> 11);
        end
    endfunction

    task automatic read_check(input string tag, input int addr, input int exp);
        rd_addr = 7'(addr);
        #0.01;
        check(tag, rd_data, 32'(exp));
    endtask

    task automatic compare_field(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = 7'(i);
            #0.01;
            check(tag, rd_data, 32'(u_m[i]));
        end
    endtask

    task automatic wait_busy_low(input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int bubbles;
    int m_mode;
    int m_cell;
    int m_count;
    int prev_mode;

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = '0;

        // Reset state and INIT length
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_fv", frame_valid, 0);
        check("rst_step", step_count, 0);
        reset = 1'b0;
        wait_busy_low(300, n);
        check("init_cycles", n, 100);
        check("idle_fv", frame_valid, 0);
        read_check("init_rd50", 50, IV);
        read_check("init_rd45", 45, 0);
        read_check("init_rd46", 46, IV);
        read_check("init_rd54", 54, IV);
        read_check("init_rd55", 55, 0);
        read_check("init_rd120", 120, 0);
        model_init();
        compare_field("init_field");

        // Single step then stop
        run = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 1);
        run = 1'b0;
        wait_busy_low(300, n);
        check("step1_cycles", n, 100);
        check("step1_count", step_count, 1);
        read_check("step1_rd50", 50, 199902343);
        read_check("step1_rd0", 0, 0);
        model_step();
        compare_field("step1_field");

        // Continuous run up to the first frame (15 more steps, no bubbles)
        run = 1'b1;
        n = 0;
        bubbles = 0;
        while (frame_valid !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1 && frame_valid !== 1'b1) bubbles++;
        end
        check("frame1_latency", n, 1501);
        check("frame1_bubbles", bubbles, 0);
        check("frame1_count", step_count, 16);
        check("frame1_busy", busy, 0);
        for (int s = 0; s < 15; s++) model_step();
        compare_field("frame1_field");

        // Frozen while unacknowledged, even with run held
        repeat (500) @(negedge clk);
        check("hold_fv", frame_valid, 1);
        check("hold_count", step_count, 16);
        compare_field("hold_field");

        // Ack: IDLE transit, then the sweep starts
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_fv", frame_valid, 0);
        check("ack_busy_idle", busy, 0);
        @(negedge clk);
        check("ack_busy_sweep", busy, 1);
        run = 1'b0;
        wait_busy_low(300, n);
        check("step17_cycles", n, 100);
        check("step17_count", step_count, 17);
        model_step();
        compare_field("step17_field");

        // Stray acks in IDLE and mid-SWEEP
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("idle_ack_busy", busy, 0);
        check("idle_ack_fv", frame_valid, 0);
        check("idle_ack_count", step_count, 17);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (40) @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("mid_ack_busy", busy, 1);
        check("mid_ack_fv", frame_valid, 0);
        wait_busy_low(300, n);
        check("mid_ack_rest", n, 59);
        check("mid_ack_count", step_count, 18);
        model_step();
        compare_field("step18_field");

        // Reset at cell 37 of the third step
        run = 1'b1;
        repeat (238) @(negedge clk);
        check("pre_rst_count", step_count, 20);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check("rst2_count", step_count, 0);
        check("rst2_fv", frame_valid, 0);
        check("rst2_busy", busy, 1);
        reset = 1'b0;
        wait_busy_low(300, n);
        check("rst2_init_cycles", n, 100);
        read_check("rst2_rd50", 50, IV);
        read_check("rst2_rd45", 45, 0);
        model_init();
        compare_field("rst2_field");

        // Full frame from a fresh field: 16 steps
        run = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("frame16_latency", n, 1601);
        check("frame16_count", step_count, 16);
        for (int s = 0; s < 16; s++) model_step();
        compare_field("frame16_field");
        run       = 1'b0;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("frame16_ack_fv", frame_valid, 0);
        check("frame16_ack_busy", busy, 0);

        // Random run/ack against a cycle-level schedule model
        m_mode  = 0;
        m_cell  = 0;
        m_count = 16;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            run       = ($urandom_range(0, 9) != 0);
            frame_ack = ($urandom_range(0, 3) == 0);
            prev_mode = m_mode;
            case (m_mode)
                0: if (run) begin m_mode = 1; m_cell = 0; end
                1: begin
                    if (m_cell == N-1) begin
                        model_step();
                        m_count = (m_count + 1) % 65536;
                        m_cell  = 0;
                        if (m_count % SPF == 0) m_mode = 2;
                        else if (!run) m_mode = 0;
                    end else begin
                        m_cell++;
                    end
                end
                default: if (frame_ack) m_mode = 0;
            endcase
            @(negedge clk);
            check("rnd_busy", busy, (m_mode == 1) ? 1 : 0);
            check("rnd_fv", frame_valid, (m_mode == 2) ? 1 : 0);
            check("rnd_count", step_count, 16'(m_count));
            if (m_mode == 2 && prev_mode != 2) begin
                compare_field("rnd_field");
                read_check("rnd_rd100", 100, 0);
            end
        end
        run       = 1'b0;
        frame_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
